// File: rtl/shift_op_issuer.sv
// Queues shift commands and issues them one at a time to an external combinational barrel shifter.
// Result valid two edges after acceptance, held until taken; `define SHIFT_ISSUE_STATS_EN adds op_count.
module shift_op_issuer #(
  parameter int W     = 8,
  parameter int SW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_din,
  input  logic [SW-1:0] in_shamt,
  input  logic          in_LR,
  input  logic          in_AL,
  output logic [W-1:0]  sh_din,
  output logic [SW-1:0] sh_shamt,
  output logic          sh_LR,
  output logic          sh_AL,
  input  logic [W-1:0]  sh_dout,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef SHIFT_ISSUE_STATS_EN
  output logic [15:0]   op_count,
`endif
  output logic [W-1:0]  out_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [W-1:0]  din;
    logic [SW-1:0] shamt;
    logic          lr;
    logic          al;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  cmd_t          mem [DEPTH];
  cmd_t          in_cmd;
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          empty;
  logic          capture;
  logic          handshake;
  state_t        state;
  state_t        state_nxt;

  assign in_cmd    = '{din: in_din, shamt: in_shamt, lr: in_LR, al: in_AL};
  assign head      = mem[rd_ptr];
  assign empty     = (count == '0);
  assign in_ready  = (count != CNT_FULL);
  assign push      = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  // Storage carries no reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          pop       = !empty;
          state_nxt = empty ? IDLE : EXEC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The EXEC cycle gives the shifter a full period between sh_* and the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_din    <= '0;
      sh_shamt  <= '0;
      sh_LR     <= 1'b0;
      sh_AL     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (pop) begin
        sh_din   <= head.din;
        sh_shamt <= head.shamt;
        sh_LR    <= head.lr;
        sh_AL    <= head.al;
      end
      if (capture) begin
        out_data  <= sh_dout;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SHIFT_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         op_count <= '0;
    else if (handshake) op_count <= op_count + 16'd1;
  end
`endif

endmodule
